// File: rtl/decode_stage.sv
// decode_stage: RV32I integer decode stage feeding the execute-stage ALU.
// Fetched instructions are decoded combinationally on entry and the decoded
// fields plus PC are stored in a 2-entry in-order skid buffer, so in_ready
// is a registered signal.
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   defined   - unsupported opcodes / bad funct7 encodings raise out_illegal
//               and are forced to alu_fn=NOP, reg_we=0
//   undefined - out_illegal tied 0, funct7 bit 30 alone selects SUB/SRA
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard all buffered and incoming instructions
//   in_valid/in_ready   fetch handshake (in_ready registered)
//   in_inst, in_pc      instruction word and its PC
//   out_valid/out_ready execute handshake
//   out_alu_fn          ALU op (0 ADD .. 10 PASSB, 31 NOP)
//   out_rs1/rs2/rd_addr register indices (raw instruction fields)
//   out_imm             decoded immediate
//   out_use_imm         operand B = out_imm
//   out_src_a_pc        operand A = out_pc
//   out_reg_we          writes rd (0 when rd==0)
//   out_pc              instruction PC
//   out_illegal         unsupported encoding flag
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_fn,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_rd_addr,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic            out_src_a_pc,
  output logic            out_reg_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_PASSB = 5'd10,
    ALU_NOP   = 5'd31
  } alu_fn_e;

  typedef struct packed {
    alu_fn_e         alu_fn;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            src_a_pc;
    logic            reg_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam entry_t RST_ENTRY = '{
    alu_fn: ALU_NOP, rs1: '0, rs2: '0, rd: '0, imm: '0,
    use_imm: 1'b0, src_a_pc: 1'b0, reg_we: 1'b0, pc: '0, illegal: 1'b0
  };

  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_writes;
  entry_t     w_dec;
  entry_t     w_entry;

  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];

  // Base decode; register indices are always the raw instruction fields.
  always_comb begin
    w_dec          = RST_ENTRY;
    w_writes       = 1'b0;
    w_dec.rs1      = in_inst[19:15];
    w_dec.rs2      = in_inst[24:20];
    w_dec.rd       = in_inst[11:7];
    w_dec.pc       = in_pc;
    case (in_inst[6:0])
      OPC_OP, OPC_OP_IMM: begin
        w_writes = 1'b1;
        case (w_f3)
          3'b000: w_dec.alu_fn = (in_inst[30] && in_inst[6:0] == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001: w_dec.alu_fn = ALU_SLL;
          3'b010: w_dec.alu_fn = ALU_SLT;
          3'b011: w_dec.alu_fn = ALU_SLTU;
          3'b100: w_dec.alu_fn = ALU_XOR;
          3'b101: w_dec.alu_fn = in_inst[30] ? ALU_SRA : ALU_SRL;
          3'b110: w_dec.alu_fn = ALU_OR;
          default: w_dec.alu_fn = ALU_AND;
        endcase
        if (in_inst[6:0] == OPC_OP_IMM) begin
          w_dec.use_imm = 1'b1;
          if (w_f3 == 3'b001 || w_f3 == 3'b101)
            w_dec.imm = XLEN'(in_inst[24:20]);
          else
            w_dec.imm = XLEN'($signed(in_inst[31:20]));
        end
      end
      OPC_LUI: begin
        w_writes      = 1'b1;
        w_dec.alu_fn  = ALU_PASSB;
        w_dec.imm     = XLEN'($signed({in_inst[31:12], 12'h000}));
        w_dec.use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        w_writes       = 1'b1;
        w_dec.alu_fn   = ALU_ADD;
        w_dec.imm      = XLEN'($signed({in_inst[31:12], 12'h000}));
        w_dec.use_imm  = 1'b1;
        w_dec.src_a_pc = 1'b1;
      end
      default: ;
    endcase
    w_dec.reg_we = w_writes && (in_inst[11:7] != 5'd0);
  end

`ifdef DECODE_ILLEGAL_EN
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    case (in_inst[6:0])
      OPC_OP:
        w_bad = !((w_f7 == 7'b0000000) ||
                  (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      OPC_OP_IMM:
        w_bad = (w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000);
      OPC_LUI, OPC_AUIPC: w_bad = 1'b0;
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_entry = w_dec;
    if (w_bad) begin
      w_entry.alu_fn  = ALU_NOP;
      w_entry.reg_we  = 1'b0;
      w_entry.illegal = 1'b1;
    end
  end
`else
  // Only bit 30 of funct7 is meaningful in this build.
  logic [5:0] w_f7_unused;
  assign w_f7_unused = {w_f7[6], w_f7[4:0]};
  assign w_entry     = w_dec;
`endif

  entry_t     r_mem [DEPTH];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_in_ready;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push = in_valid && r_in_ready && !flush;
  assign w_pop  = (r_count != 2'd0) && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem      <= '{default: RST_ENTRY};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_in_ready <= (32'(w_count_nxt) < DEPTH);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_count != 2'd0);
  assign out_alu_fn   = r_mem[r_rd_ptr].alu_fn;
  assign out_rs1_addr = r_mem[r_rd_ptr].rs1;
  assign out_rs2_addr = r_mem[r_rd_ptr].rs2;
  assign out_rd_addr  = r_mem[r_rd_ptr].rd;
  assign out_imm      = r_mem[r_rd_ptr].imm;
  assign out_use_imm  = r_mem[r_rd_ptr].use_imm;
  assign out_src_a_pc = r_mem[r_rd_ptr].src_a_pc;
  assign out_reg_we   = r_mem[r_rd_ptr].reg_we;
  assign out_pc       = r_mem[r_rd_ptr].pc;
  assign out_illegal  = r_mem[r_rd_ptr].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal checks plus
// randomized traffic checked every cycle against a queue-based model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_fn;
  logic [4:0]  out_rs1_addr;
  logic [4:0]  out_rs2_addr;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_src_a_pc;
  logic        out_reg_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_fn(out_alu_fn), .out_rs1_addr(out_rs1_addr),
    .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_src_a_pc(out_src_a_pc),
    .out_reg_we(out_reg_we), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [4:0]  fn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        src_a_pc;
    logic        reg_we;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  // Reference decode from the ISA tables: funct3 picks a base op, bit 30
  // bumps ADD->SUB (register form only) and SRL->SRA.
  function automatic exp_t mdec(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    int fn_tab [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit known = 1'b1;
    e.fn = 5'd31; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.imm = 32'd0; e.use_imm = 1'b0; e.src_a_pc = 1'b0; e.reg_we = 1'b0;
    e.pc = pc; e.ill = 1'b0;
    case (ins[6:0])
      7'h33: e.fn = 5'(fn_tab[f3] + ((ins[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
      7'h13: begin
        e.fn = 5'(fn_tab[f3] + ((ins[30] && f3 == 3'd5) ? 1 : 0));
        e.use_imm = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) e.imm = {27'd0, ins[24:20]};
        else e.imm = $signed(ins) >>> 20;
      end
      7'h37: begin e.fn = 5'd10; e.imm = ins & 32'hFFFFF000; e.use_imm = 1'b1; end
      7'h17: begin
        e.fn = 5'd0; e.imm = ins & 32'hFFFFF000; e.use_imm = 1'b1; e.src_a_pc = 1'b1;
      end
      default: known = 1'b0;
    endcase
    if (known) e.reg_we = (e.rd != 5'd0);
`ifdef DECODE_ILLEGAL_EN
    if (!known ||
        (ins[6:0] == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ||
        (ins[6:0] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 &&
         !(f3 == 3'd5 && f7 == 7'h20))) begin
      e.ill = 1'b1; e.fn = 5'd31; e.reg_we = 1'b0;
    end
`else
    if (f7 == 7'h7F && !known) e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Model state: expected buffer contents and expected in_ready.
  exp_t q[$];
  bit   m_ready = 1'b1;
  bit   m_on    = 1'b0;

  always @(negedge clk) begin
    if (m_on) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      if (q.size() != 0 && out_valid) begin
        chk("alu_fn", {27'd0, out_alu_fn}, {27'd0, q[0].fn});
        chk("rs1", {27'd0, out_rs1_addr}, {27'd0, q[0].rs1});
        chk("rs2", {27'd0, out_rs2_addr}, {27'd0, q[0].rs2});
        chk("rd", {27'd0, out_rd_addr}, {27'd0, q[0].rd});
        chk("imm", out_imm, q[0].imm);
        chk("use_imm", {31'd0, out_use_imm}, {31'd0, q[0].use_imm});
        chk("src_a_pc", {31'd0, out_src_a_pc}, {31'd0, q[0].src_a_pc});
        chk("reg_we", {31'd0, out_reg_we}, {31'd0, q[0].reg_we});
        chk("pc", out_pc, q[0].pc);
        chk("illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
      end
    end
    if (rst || flush) begin
      q.delete();
      m_ready = 1'b1;
      if (rst) m_on = 1'b1;
    end else if (m_on) begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && m_ready) q.push_back(mdec(in_inst, in_pc));
      m_ready = (q.size() < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] inst, logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] ins = $urandom;
    int unsigned sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: begin ins[6:0] = 7'h33; if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      3, 4, 5: begin ins[6:0] = 7'h13; if ($urandom_range(0, 3) != 0 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      6:       ins[6:0] = 7'h37;
      7:       ins[6:0] = 7'h17;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 32'd0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_fn", {27'd0, out_alu_fn}, 32'd31);
    chk("rst_rd", {27'd0, out_rd_addr}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_reg_we", {31'd0, out_reg_we}, 32'd0);
    chk("rst_use_imm", {31'd0, out_use_imm}, 32'd0);

    out_ready = 1'b1;
    send(32'h00500093, 32'h100);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_fn", {27'd0, out_alu_fn}, 32'd0);
    chk("addi_rs1", {27'd0, out_rs1_addr}, 32'd0);
    chk("addi_rd", {27'd0, out_rd_addr}, 32'd1);
    chk("addi_imm", out_imm, 32'h00000005);
    chk("addi_use_imm", {31'd0, out_use_imm}, 32'd1);
    chk("addi_reg_we", {31'd0, out_reg_we}, 32'd1);
    send(32'hFFF00093, 32'h104);
    chk("addin_imm", out_imm, 32'hFFFFFFFF);
    send(32'h402081B3, 32'h108);
    chk("sub_fn", {27'd0, out_alu_fn}, 32'd1);
    chk("sub_rs1", {27'd0, out_rs1_addr}, 32'd1);
    chk("sub_rs2", {27'd0, out_rs2_addr}, 32'd2);
    chk("sub_rd", {27'd0, out_rd_addr}, 32'd3);
    chk("sub_use_imm", {31'd0, out_use_imm}, 32'd0);
    send(32'h40335293, 32'h10C);
    chk("srai_fn", {27'd0, out_alu_fn}, 32'd7);
    chk("srai_imm", out_imm, 32'd3);
    send(32'h123453B7, 32'h110);
    chk("lui_fn", {27'd0, out_alu_fn}, 32'd10);
    chk("lui_imm", out_imm, 32'h12345000);
    send(32'hFFFFFFFF, 32'h114);
    chk("bad_fn", {27'd0, out_alu_fn}, 32'd31);
    chk("bad_reg_we", {31'd0, out_reg_we}, 32'd0);
`ifdef DECODE_ILLEGAL_EN
    chk("bad_illegal", {31'd0, out_illegal}, 32'd1);
`else
    chk("bad_illegal", {31'd0, out_illegal}, 32'd0);
`endif
    tick();

    // Backpressure: three back-to-back pushes with execute stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h200; tick();
    in_inst = 32'h00200113; in_pc = 32'h204; tick();
    in_inst = 32'h00300193; in_pc = 32'h208;
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_pc", out_pc, 32'h200);
    tick();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    chk("bp_second_pc", out_pc, 32'h204);
    tick();
    in_valid = 1'b0;
    chk("bp_third_pc", out_pc, 32'h208);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush with a full buffer and a pending input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h300; tick();
    in_pc = 32'h304; tick();
    in_pc = 32'h308; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_pc = 32'h30C; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_empty_drop", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Same with reset.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00B00093; in_pc = 32'h400; tick();
    in_pc = 32'h404; tick();
    in_pc = 32'h408; rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_alu_fn", {27'd0, out_alu_fn}, 32'd31);
    chk("rst2_pc", out_pc, 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 255) == 0);
      in_inst   = gen_inst();
      in_pc     = $urandom & 32'hFFFFFFFC;
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
